// File: rtl/uart_bus_master.sv
// Drives a 16550-style UART register port: programs the divisor and line format, then polls LSR to move bytes.
// Optional build macro UART_MST_TIMEOUT_EN adds a sticky flag for a transmitter that never frees THR.
module uart_bus_master #(
  parameter logic [15:0] DIV_RST = 16'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_start,
  input  logic [15:0] cfg_div,
  output logic        init_done,
  input  logic        tx_valid,
  input  logic [7:0]  tx_data,
  output logic        tx_ready,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic [4:0]  addr,
  output logic        en,
  output logic        we,
  output logic        rd,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        tx_timeout
);

  localparam logic [4:0] A_THR = 5'h00;
  localparam logic [4:0] A_DLH = 5'h04;
  localparam logic [4:0] A_LCR = 5'h0C;
  localparam logic [4:0] A_LSR = 5'h14;

  typedef enum logic [3:0] {
    S_IDLE, S_C_LCR1, S_C_DLL, S_C_DLH, S_C_LCR0,
    S_POLL, S_WR_THR, S_GAP, S_RD_POP, S_RD_CAP
  } state_t;

  state_t      r_state;
  logic [15:0] r_div;
  logic        r_restart;
  logic        r_init_done;
  logic        r_tx_ready;
  logic        r_rx_valid;
  logic [7:0]  r_rx_data;
  logic        r_en;
  logic        r_we;
  logic        r_rd;
  logic [4:0]  r_addr;
  logic [31:0] r_wdata;

  // LSR bits are meaningful only while addr selects LSR, i.e. in POLL.
  logic w_dr;
  logic w_thre;
  logic w_unused_rdata;
  assign w_dr           = rdata[0];
  assign w_thre         = rdata[5];
  assign w_unused_rdata = ^{rdata[31:6], rdata[4:1]};

  // Outputs are registered: each transition loads the bus values of the state being entered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_restart   <= 1'b0;
      r_init_done <= 1'b0;
      r_tx_ready  <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_rx_data   <= 8'd0;
      r_en        <= 1'b0;
      r_we        <= 1'b0;
      r_rd        <= 1'b0;
      r_addr      <= 5'd0;
      r_wdata     <= 32'd0;
    end else begin
      r_en       <= 1'b0;
      r_we       <= 1'b0;
      r_rd       <= 1'b0;
      r_addr     <= 5'd0;
      r_wdata    <= 32'd0;
      r_tx_ready <= 1'b0;
      if (r_rx_valid && rx_ready) r_rx_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cfg_start) begin
            r_div   <= (cfg_div != 16'd0) ? cfg_div : DIV_RST;
            r_state <= S_C_LCR1;
            r_en    <= 1'b1;
            r_we    <= 1'b1;
            r_addr  <= A_LCR;
            r_wdata <= 32'h0000_0080;
          end
        end
        S_C_LCR1: begin
          r_state <= S_C_DLL;
          r_en    <= 1'b1;
          r_we    <= 1'b1;
          r_addr  <= A_THR;
          r_wdata <= {24'd0, r_div[7:0]};
        end
        S_C_DLL: begin
          r_state <= S_C_DLH;
          r_en    <= 1'b1;
          r_we    <= 1'b1;
          r_addr  <= A_DLH;
          r_wdata <= {24'd0, r_div[15:8]};
        end
        S_C_DLH: begin
          r_state <= S_C_LCR0;
          r_en    <= 1'b1;
          r_we    <= 1'b1;
          r_addr  <= A_LCR;
          r_wdata <= 32'h0000_0003;
        end
        S_C_LCR0: begin
          r_state     <= S_POLL;
          r_init_done <= 1'b1;
          r_en        <= 1'b1;
          r_addr      <= A_LSR;
        end
        S_POLL: begin
          if (cfg_start) begin
            r_div     <= (cfg_div != 16'd0) ? cfg_div : DIV_RST;
            r_restart <= 1'b1;
            r_state   <= S_GAP;
          end else if (w_dr && !r_rx_valid) begin
            r_state <= S_RD_POP;
            r_en    <= 1'b1;
            r_rd    <= 1'b1;
            r_addr  <= A_THR;
          end else if (w_thre && tx_valid) begin
            r_state    <= S_WR_THR;
            r_tx_ready <= 1'b1;
            r_en       <= 1'b1;
            r_we       <= 1'b1;
            r_addr     <= A_THR;
            r_wdata    <= {24'd0, tx_data};
          end else begin
            r_en   <= 1'b1;
            r_addr <= A_LSR;
          end
        end
        S_WR_THR: r_state <= S_GAP;
        S_RD_POP: begin
          r_state <= S_RD_CAP;
          r_en    <= 1'b1;
          r_addr  <= A_THR;
        end
        S_RD_CAP: begin
          r_rx_data  <= rdata[7:0];
          r_rx_valid <= 1'b1;
          r_state    <= S_GAP;
        end
        S_GAP: begin
          if (r_restart) begin
            r_restart   <= 1'b0;
            r_init_done <= 1'b0;
            r_state     <= S_C_LCR1;
            r_en        <= 1'b1;
            r_we        <= 1'b1;
            r_addr      <= A_LCR;
            r_wdata     <= 32'h0000_0080;
          end else begin
            r_state <= S_POLL;
            r_en    <= 1'b1;
            r_addr  <= A_LSR;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef UART_MST_TIMEOUT_EN
  logic [15:0] r_to_cnt;
  logic        r_tx_timeout;
  logic        w_stall;
  assign w_stall = (r_state == S_POLL) && tx_valid && !w_thre;

  // Counter saturates at all-ones; the flag holds until reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_to_cnt     <= 16'd0;
      r_tx_timeout <= 1'b0;
    end else begin
      if (r_state == S_WR_THR)
        r_to_cnt <= 16'd0;
      else if (w_stall && (r_to_cnt != 16'hFFFF))
        r_to_cnt <= r_to_cnt + 16'd1;
      if (r_to_cnt == 16'hFFFF) r_tx_timeout <= 1'b1;
    end
  end
  assign tx_timeout = r_tx_timeout;
`else
  assign tx_timeout = 1'b0;
`endif

  assign init_done = r_init_done;
  assign tx_ready  = r_tx_ready;
  assign rx_valid  = r_rx_valid;
  assign rx_data   = r_rx_data;
  assign en        = r_en;
  assign we        = r_we;
  assign rd        = r_rd;
  assign addr      = r_addr;
  assign wdata     = r_wdata;

endmodule

// File: tb/tb_uart_bus_master.sv
// Bench for uart_bus_master: table-driven configuration checks, directed corner sequences,
// and a randomized transfer run against a UART peripheral model with an RX FIFO and THR log.
module tb_uart_bus_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_start;
  logic [15:0] cfg_div;
  logic        init_done;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic [4:0]  addr;
  logic        en;
  logic        we;
  logic        rd;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        tx_timeout;

  uart_bus_master #(.DIV_RST(16'h0010)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_div(cfg_div), .init_done(init_done),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .addr(addr), .en(en), .we(we), .rd(rd), .wdata(wdata), .rdata(rdata),
    .tx_timeout(tx_timeout)
  );

  always #5 clk = ~clk;

  // Peripheral model: RX FIFO feeding RBR on a read pop, THRE driven by the bench, THR writes logged.
  logic [7:0] rx_mem [0:63];
  int         rx_wr = 0;
  int         rx_rd = 0;
  logic [7:0] rbr = 8'h00;
  logic       thre;
  logic       dr;
  logic [7:0] thr_log [0:255];
  int         thr_n = 0;

  assign dr = (rx_wr != rx_rd);

  always_comb begin
    rdata = 32'd0;
    if (addr == 5'h14)      rdata = {24'hC3C3C3, 2'b11, thre, 4'b1010, dr};
    else if (addr == 5'h00) rdata = {24'h5A5A5A, rbr};
  end

  always @(posedge clk) begin
    if (en && rd && addr == 5'h00 && rx_wr != rx_rd) begin
      rbr   <= rx_mem[rx_rd & 63];
      rx_rd <= rx_rd + 1;
    end
    if (en && we && addr == 5'h00) begin
      thr_log[thr_n & 255] <= wdata[7:0];
      thr_n <= thr_n + 1;
    end
  end

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [15:0] div;
    logic [7:0]  dll;
    logic [7:0]  dlh;
  } cfg_vec_t;
  cfg_vec_t cv [4];

  localparam int N = 24;
  logic [7:0] txl [N];
  logic [7:0] rxl [N];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] bus();
    return {21'd0, en, we, rd, 3'd0, addr, wdata};
  endfunction

  function automatic logic [63:0] mk(input logic e, input logic w, input logic r,
                                     input logic [4:0] a, input logic [31:0] d);
    return {21'd0, e, w, r, 3'd0, a, d};
  endfunction

  task automatic push_rx(input logic [7:0] b);
    rx_mem[rx_wr & 63] = b;
    rx_wr++;
  endtask

  task automatic do_reset();
    rst = 1'b0; cfg_start = 1'b0; tx_valid = 1'b0; rx_ready = 1'b0; thre = 1'b0;
    rx_wr = rx_rd;
    step();
    rst = 1'b1;
  endtask

  // cfg_start is held a second cycle with a different divisor, which must be ignored.
  task automatic run_cfg(input cfg_vec_t v);
    cfg_div = v.div; cfg_start = 1'b1;
    step();
    chk("cfg_lcr1", bus(), mk(1, 1, 0, 5'h0C, 32'h80));
    chk("cfg_init_lo", init_done, 0);
    cfg_div = 16'h9999;
    step();
    cfg_start = 1'b0;
    chk("cfg_dll", bus(), mk(1, 1, 0, 5'h00, {24'd0, v.dll}));
    step();
    chk("cfg_dlh", bus(), mk(1, 1, 0, 5'h04, {24'd0, v.dlh}));
    step();
    chk("cfg_lcr0", bus(), mk(1, 1, 0, 5'h0C, 32'h03));
    chk("cfg_init_pre", init_done, 0);
    step();
    chk("cfg_init_done", init_done, 1);
    chk("cfg_poll", bus(), mk(1, 0, 0, 5'h14, 32'h0));
  endtask

  initial begin
    int rdc;
    int nonidle;
    int tx_i, rx_push, rx_got, viol, cyc, thr_base;
    logic hs;

    cv[0] = '{div: 16'h0145, dll: 8'h45, dlh: 8'h01};
    cv[1] = '{div: 16'h0000, dll: 8'h10, dlh: 8'h00};
    cv[2] = '{div: 16'hBEEF, dll: 8'hEF, dlh: 8'hBE};
    cv[3] = '{div: 16'h0001, dll: 8'h01, dlh: 8'h00};

    rst = 1'b0; cfg_start = 1'b0; cfg_div = 16'd0; tx_valid = 1'b0; tx_data = 8'd0;
    rx_ready = 1'b0; thre = 1'b0;
    step(); step();
    chk("rst_bus", bus(), 64'd0);
    chk("rst_flags", {init_done, tx_ready, rx_valid, tx_timeout}, 4'b0000);
    chk("rst_rxdata", rx_data, 8'h00);
    rst = 1'b1;
    step(); step();
    chk("idle_bus", bus(), 64'd0);

    for (int i = 0; i < 4; i++) begin
      do_reset();
      run_cfg(cv[i]);
    end

    // Reset in the middle of configuration
    do_reset();
    cfg_div = 16'h0145; cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk("midrst_bus", bus(), 64'd0);
    chk("midrst_init", init_done, 0);
    rst = 1'b1;
    nonidle = 0;
    repeat (4) begin
      step();
      if (en || we || rd) nonidle++;
    end
    chk("midrst_quiet", nonidle, 0);

    // Single transmit
    do_reset();
    run_cfg(cv[0]);
    thre = 1'b1; tx_valid = 1'b1; tx_data = 8'hA5;
    step();
    chk("tx_write", bus(), mk(1, 1, 0, 5'h00, 32'h0000_00A5));
    chk("tx_ready_hi", tx_ready, 1);
    step();
    tx_valid = 1'b0;
    chk("tx_gap", bus(), 64'd0);
    chk("tx_ready_lo", tx_ready, 0);
    step();
    chk("tx_poll", bus(), mk(1, 0, 0, 5'h14, 32'h0));

    // Receive takes priority over a pending transmit
    thre = 1'b1; tx_valid = 1'b1; tx_data = 8'h5A; rx_ready = 1'b0;
    push_rx(8'h3C);
    step();
    chk("rx_pop", bus(), mk(1, 0, 1, 5'h00, 32'h0));
    chk("rx_pop_noready", tx_ready, 0);
    step();
    chk("rx_cap", bus(), mk(1, 0, 0, 5'h00, 32'h0));
    step();
    chk("rx_gap", bus(), 64'd0);
    chk("rx_valid_set", rx_valid, 1);
    chk("rx_data_3c", rx_data, 8'h3C);
    step();
    chk("rx_poll", bus(), mk(1, 0, 0, 5'h14, 32'h0));
    step();
    chk("rx_then_tx", bus(), mk(1, 1, 0, 5'h00, 32'h0000_005A));
    chk("rx_then_txrdy", tx_ready, 1);
    step();
    tx_valid = 1'b0;
    step();

    // Held byte blocks further pops until the sink takes it
    push_rx(8'h77);
    rdc = 0;
    repeat (6) begin
      step();
      if (rd) rdc++;
    end
    chk("hold_no_rd", rdc, 0);
    chk("hold_valid", rx_valid, 1);
    chk("hold_data", rx_data, 8'h3C);
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    chk("hs_clear", rx_valid, 0);
    step();
    chk("hs_pop", bus(), mk(1, 0, 1, 5'h00, 32'h0));
    step(); step();
    chk("hs_data2", {rx_valid, rx_data}, {1'b1, 8'h77});
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    chk("hs_clear2", rx_valid, 0);

    // Reconfiguration from POLL passes through GAP
    cfg_div = 16'h0203; cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    chk("rcfg_gap", bus(), 64'd0);
    step();
    chk("rcfg_lcr1", bus(), mk(1, 1, 0, 5'h0C, 32'h80));
    chk("rcfg_init_lo", init_done, 0);
    step();
    chk("rcfg_dll", bus(), mk(1, 1, 0, 5'h00, 32'h03));
    step();
    chk("rcfg_dlh", bus(), mk(1, 1, 0, 5'h04, 32'h02));
    step(); step();
    chk("rcfg_done", {init_done, bus()}, {1'b1, mk(1, 0, 0, 5'h14, 32'h0)});

    // Transmitter stalled on THRE=0
    thre = 1'b0; tx_valid = 1'b1; tx_data = 8'h11;
    repeat (50) step();
    chk("stall_noready", tx_ready, 0);
    chk("stall_noto", tx_timeout, 0);
`ifdef UART_MST_TIMEOUT_EN
    repeat (65000) step();
    chk("to_early", tx_timeout, 0);
    repeat (600) step();
    chk("to_set", tx_timeout, 1);
    rst = 1'b0;
    step();
    chk("to_rst", tx_timeout, 0);
    rst = 1'b1;
`endif
    tx_valid = 1'b0;

    // Randomized traffic against the peripheral model
    do_reset();
    run_cfg(cv[2]);
    for (int k = 0; k < N; k++) begin
      txl[k] = 8'($urandom_range(0, 255));
      rxl[k] = 8'($urandom_range(0, 255));
    end
    tx_i = 0; rx_push = 0; rx_got = 0; viol = 0; cyc = 0;
    thr_base = thr_n;
    while ((tx_i < N || rx_got < N) && cyc < 4000) begin
      thre = 1'($urandom_range(0, 1));
      rx_ready = ($urandom_range(0, 2) != 0);
      if (rx_push < N && $urandom_range(0, 3) == 0) begin
        push_rx(rxl[rx_push]);
        rx_push++;
      end
      if (!tx_valid && tx_i < N && $urandom_range(0, 1) == 1) begin
        tx_valid = 1'b1;
        tx_data  = txl[tx_i];
      end
      if (rd && rx_valid) viol++;
      if (tx_ready && bus() != mk(1, 1, 0, 5'h00, {24'd0, tx_data})) viol++;
      if (rx_valid && rx_ready) begin
        if (rx_got < N) chk("rnd_rx_byte", rx_data, rxl[rx_got]);
        rx_got++;
      end
      hs = tx_valid && tx_ready;
      step();
      cyc++;
      if (hs) begin
        tx_valid = 1'b0;
        tx_i++;
      end
    end
    chk("rnd_tx_count", tx_i, N);
    chk("rnd_rx_count", rx_got, N);
    chk("rnd_protocol", viol, 0);
    chk("rnd_thr_writes", thr_n - thr_base, N);
    for (int k = 0; k < N; k++)
      chk("rnd_thr_byte", thr_log[(thr_base + k) & 255], txl[k]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_bus_master.md
UART_BUS_MASTER -- requirements
Module: uart_bus_master

Interface
REQ-001 Parameter DIV_RST, default 16'd0, divisor loaded when cfg_div is unused; cfg_div takes precedence when nonzero.
REQ-002 clk  input  1  sole clock; all logic on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 cfg_start  input  1  one-cycle pulse; launches the divisor/line configuration sequence.
REQ-005 cfg_div  input  16  baud divisor; sampled on cfg_start.
REQ-006 init_done  output  1  high once configuration completes.
REQ-007 tx_valid, tx_data  input  1, 8  byte to transmit, valid/ready handshake.
REQ-008 tx_ready  output  1  accepts tx_data this cycle.
REQ-009 rx_valid, rx_data  output  1, 8  received byte, valid/ready handshake.
REQ-010 rx_ready  input  1  sink accepts rx_data.
REQ-011 addr, en, we, rd  output  5, 1, 1, 1  register-port controls toward the UART peripheral.
REQ-012 wdata  output  32  register write data; rdata  input  32  register read data, combinational from addr.
REQ-013 tx_timeout  output  1  sticky THRE-timeout flag (see Configuration).

Function
REQ-014 Register map used: 0x00 THR/RBR (DLL when LCR[7]=1), 0x04 DLH when LCR[7]=1, 0x0C LCR, 0x14 LSR; LSR[0]=DR, LSR[5]=THRE.
REQ-015 Bus idle cycle: en=0, we=0, rd=0, addr=0, wdata=0.
REQ-016 Write cycle: exactly one cycle with en=1, we=1, rd=0, addr and wdata valid.
REQ-017 States: IDLE, C_LCR1, C_DLL, C_DLH, C_LCR0, POLL, WR_THR, GAP, RD_POP, RD_CAP.
REQ-018 IDLE -> C_LCR1 on cfg_start; divisor latched = cfg_div if nonzero, else DIV_RST.
REQ-019 C_LCR1 writes LCR=0x80; C_DLL writes divisor[7:0]; C_DLH writes divisor[15:8]; C_LCR0 writes LCR=0x03; then POLL with init_done=1; one state per cycle.
REQ-020 POLL: en=1, we=0, rd=0, addr=0x14; LSR sampled from rdata same cycle.
REQ-021 POLL priority: DR=1 and rx_valid=0 -> RD_POP; else THRE=1 and tx_valid=1 -> WR_THR; else stay.
REQ-022 WR_THR: write tx_data to 0x00; tx_ready=1 in this cycle only; next state GAP.
REQ-023 GAP: one bus-idle cycle so the registered THRE/DR status reflects the push/pop; then POLL.
REQ-024 RD_POP: en=1, rd=1, we=0, addr=0x00 for one cycle (peripheral FIFO pops, RBR loads next edge).
REQ-025 RD_CAP: en=1, rd=0, addr=0x00; rdata[7:0] captured into rx_data, rx_valid set; next state GAP.
REQ-026 rx_valid stays high, rx_data stable, until rx_valid&rx_ready; cleared the following cycle.
REQ-027 A second RD_POP never occurs while rx_valid=1 (no byte loss).
REQ-028 cfg_start outside IDLE is ignored; cfg_start while init_done=1 in POLL restarts configuration at C_LCR1 after the current state completes GAP.
REQ-029 tx_ready=0 in every state other than WR_THR.

Reset
REQ-030 rst=0 at posedge clk: state IDLE, init_done=0, tx_ready=0, rx_valid=0, rx_data=0, tx_timeout=0, bus idle per REQ-015.
REQ-031 Reset mid-sequence aborts with no further bus cycles; the bus idles in the cycle after the reset edge.

Configuration
REQ-032 Macro UART_MST_TIMEOUT_EN defined: 16-bit counter increments each POLL cycle with tx_valid=1 and THRE=0, clears on WR_THR; at 16'hFFFF tx_timeout sets, sticky until reset.
REQ-033 Macro undefined: no counter; tx_timeout tied 0.

Verification
REQ-034 cfg_start with cfg_div=16'h0145 -> writes LCR=0x80, DLL=0x45, DLH=0x01, LCR=0x03 on four consecutive cycles; init_done=1 next cycle.
REQ-035 cfg_div=0, DIV_RST=16'h0010 -> DLL=0x10, DLH=0x00.
REQ-036 After init, tx_valid with tx_data=0xA5, LSR=0x20 -> one write of 0x000000A5 to 0x00, tx_ready one cycle, GAP, then POLL.
REQ-037 LSR=0x21, RBR=0x3C, tx_valid=1 -> RD_POP then RD_CAP first, rx_data=0x3C, rx_valid=1; THR write only after the next POLL.
REQ-038 rx_ready=0 with rx_valid=1 and DR held 1 -> no rd pulse until rx_ready=1 handshake completes.
REQ-039 UART_MST_TIMEOUT_EN, THRE held 0, tx_valid=1 for 65535 POLL cycles -> tx_timeout=1; rst=0 clears it.
